// File: rtl/seq_detect_mealy_prog.sv
// Runtime-programmable Mealy serial pattern detector with valid qualifier and saturating match counter.
// z is combinational on the completing bit; configuration, history and count update on the clock edge.
module seq_detect_mealy_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1110,
  parameter int                 DEF_LEN     = 4,
  parameter bit                 DEF_OVERLAP = 1'b0,
  localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               z,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(2);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);

  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;
  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   fill;

  logic               accept;
  logic               fill_ok;
  logic               hit;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   len_clamped;

  // Candidate pattern: stored history with the live bit appended as the last-received bit.
  assign window  = {hist, x};
  assign accept  = in_valid & ~cfg_load;
  assign fill_ok = (fill >= (len - LEN_W'(1)));

  // Only the low len bits take part in the comparison.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
  end

  assign hit = accept & fill_ok & (((window ^ pat) & mask) == '0);
  assign z   = hit & ~rst;

  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len < LEN_MIN) begin
      len_clamped = LEN_MIN;
    end else if (cfg_len > LEN_MAX) begin
      len_clamped = LEN_MAX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat         <= DEF_PATTERN;
      len         <= LEN_W'(DEF_LEN);
      ovl         <= DEF_OVERLAP;
      hist        <= '0;
      fill        <= '0;
      match_count <= '0;
    end else if (cfg_load) begin
      pat         <= cfg_pattern;
      len         <= len_clamped;
      ovl         <= cfg_overlap;
      hist        <= '0;
      fill        <= '0;
      match_count <= '0;
    end else if (accept) begin
      hist <= window[MAX_LEN-2:0];
      // A non-overlapping detect consumes the whole window, so the next match needs len fresh bits.
      if (hit && !ovl) begin
        fill <= '0;
      end else if (fill != FILL_MAX) begin
        fill <= fill + LEN_W'(1);
      end
      if (hit && (match_count != {CNT_W{1'b1}})) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule
